// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, MDU multi-cycle stalls, branch flush/redirect
// and EX-stage operand forwarding, plus a saturating stall-cycle counter.
//
// state | meaning
// RUN   | normal issue; branch, MDU start and load-use are evaluated each cycle
// MDU   | multi-cycle mult/div occupying EX; pipeline held until cnt reaches 0
module hazard_ctrl #(
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UseRs_ID,
    input  logic             UseRt_ID,
    input  logic [4:0]       Rs_EX,
    input  logic [4:0]       Rt_EX,
    input  logic [4:0]       Rd_EX,
    input  logic             RegWrite_EX,
    input  logic             MemToReg_EX,
    input  logic [4:0]       Rd_MEM,
    input  logic             RegWrite_MEM,
    input  logic [4:0]       Rd_WB,
    input  logic             RegWrite_WB,
    input  logic             MduStart_EX,
    input  logic             BrResolve_EX,
    input  logic [31:0]      BrTarget_EX,
    output logic             AnyStall,
    output logic             Bubble_EX,
    output logic             Flush_ID,
    output logic             BranchTaken_EX,
    output logic [31:0]      RedirectPc_EX,
    output logic [1:0]       FwdA_EX,
    output logic [1:0]       FwdB_EX,
    output logic             MduBusy,
    output logic [CNT_W-1:0] StallCnt
);

    typedef enum logic {RUN, MDU} state_t;

    // The start cycle is spent in RUN, so MDU holds for MDU_LAT-1 cycles.
    localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 2);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       wr_mem, input logic [4:0] rd_mem,
                                           input logic       wr_wb,  input logic [4:0] rd_wb);
        logic [1:0] sel;
        sel = 2'd0;
        if (wr_mem && rd_mem != 5'd0 && rd_mem == src)
            sel = 2'd1;
        else if (wr_wb && rd_wb != 5'd0 && rd_wb == src)
            sel = 2'd2;
        return sel;
    endfunction

    assign load_use = RegWrite_EX && MemToReg_EX && (Rd_EX != 5'd0) &&
                      ((UseRs_ID && Rs_ID == Rd_EX) || (UseRt_ID && Rt_ID == Rd_EX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= 4'd0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (AnyStall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (!BrResolve_EX && MduStart_EX) begin
                    state_nx = MDU;
                    cnt_nx   = CNT_INIT;
                end
            end
            MDU: begin
                if (cnt == 4'd0)
                    state_nx = RUN;
                else
                    cnt_nx = cnt - 1'b1;
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        AnyStall       = 1'b0;
        Bubble_EX      = 1'b0;
        Flush_ID       = 1'b0;
        BranchTaken_EX = 1'b0;
        RedirectPc_EX  = 32'd0;
        FwdA_EX        = 2'd0;
        FwdB_EX        = 2'd0;
        MduBusy        = 1'b0;
        StallCnt       = '0;
        if (!reset) begin
            FwdA_EX  = fwd_sel(Rs_EX, RegWrite_MEM, Rd_MEM, RegWrite_WB, Rd_WB);
            FwdB_EX  = fwd_sel(Rt_EX, RegWrite_MEM, Rd_MEM, RegWrite_WB, Rd_WB);
            StallCnt = stall_cnt;
            case (state)
                RUN: begin
                    if (BrResolve_EX) begin
                        BranchTaken_EX = 1'b1;
                        RedirectPc_EX  = BrTarget_EX;
                        Flush_ID       = 1'b1;
                        Bubble_EX      = 1'b1;
                    end else if (MduStart_EX) begin
                        AnyStall = 1'b1;
                    end else if (load_use) begin
                        AnyStall  = 1'b1;
                        Bubble_EX = 1'b1;
                    end
                end
                MDU: begin
                    AnyStall = 1'b1;
                    MduBusy  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
